// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and default parameters for the bit_serializer slice.
//  state_e          FSM state encoding (IDLE, SHIFT, DONE)
//  DefWidth         default word width
//  DefMsbFirst      default bit order (1: MSB first)
//  DefHoldCycles    default number of enabled clocks each bit is held
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DefWidth      = 8;
  localparam bit          DefMsbFirst   = 1'b1;
  localparam int unsigned DefHoldCycles = 1;

endpackage

// File: rtl/hold_counter.sv
// hold_counter: down-counter that paces how long each serial bit stays on x.
//  CLK    in  clock, rising edge
//  RESET  in  asynchronous active-high reset
//  load   in  restart the count for a fresh word
//  en     in  count this cycle
//  tc     out terminal count: the current cycle is the last hold cycle of the bit
module hold_counter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] Reload = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == '0);

  // Reloads explicitly on terminal count so the counter never relies on wrap-around.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load || (en && tc)) begin
      cnt_q <= Reload;
    end else if (en) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: turns a parallel word into a serial stream on x for the sequence detector.
//  CLK         in   clock, rising edge
//  RESET       in   asynchronous active-high reset
//  load_data   in   word to serialize
//  load_valid  in   load_data is valid
//  load_ready  out  a word is accepted this cycle (idle)
//  en          in   1: advance; 0: freeze hold count, bit index and x
//  x           out  serial bit
//  x_valid     out  x carries a payload bit
//  busy        out  word in flight (SHIFT or DONE)
//  done        out  one-cycle pulse after the last bit
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter bit          MSB_FIRST   = DefMsbFirst,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LastIdx = BW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bit_idx_q;
  logic             accept;
  logic             shift_en;
  logic             hold_tc;

  // Bit that leaves the word next, given the configured order.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Word with the head bit consumed.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign load_ready = (state_q == ST_IDLE);
  assign accept     = load_ready && load_valid;
  assign shift_en   = en && (state_q == ST_SHIFT);

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .CLK  (CLK),
    .RESET(RESET),
    .load (accept),
    .en   (shift_en),
    .tc   (hold_tc)
  );

  // x is registered from the head of the word; shreg_q keeps only the bits not yet shown.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            state_q   <= ST_SHIFT;
            shreg_q   <= drop_head(load_data);
            bit_idx_q <= '0;
            x         <= head(load_data);
            x_valid   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (en && hold_tc) begin
            if (bit_idx_q == LastIdx) begin
              state_q <= ST_DONE;
              x       <= 1'b0;
              x_valid <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + BW'(1);
              x         <= head(shreg_q);
              shreg_q   <= drop_head(shreg_q);
            end
          end
        end
        ST_DONE: begin
          // DONE lasts one cycle regardless of en.
          state_q <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: three serializer configurations (MSB/hold 1, LSB/hold 1, MSB/hold 3)
// driven by directed and random words, checked against a stream model of the bit sequence.
module tb_bit_serializer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] load_data;
  logic [2:0] lv;
  logic [2:0] en;
  logic [2:0] rdy_o;
  logic [2:0] x_o;
  logic [2:0] xv_o;
  logic [2:0] busy_o;
  logic [2:0] done_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .HOLD_CYCLES(1)) dut_msb (
    .CLK(CLK), .RESET(RESET), .load_data(load_data), .load_valid(lv[0]), .load_ready(rdy_o[0]),
    .en(en[0]), .x(x_o[0]), .x_valid(xv_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .HOLD_CYCLES(1)) dut_lsb (
    .CLK(CLK), .RESET(RESET), .load_data(load_data), .load_valid(lv[1]), .load_ready(rdy_o[1]),
    .en(en[1]), .x(x_o[1]), .x_valid(xv_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .HOLD_CYCLES(3)) dut_hold3 (
    .CLK(CLK), .RESET(RESET), .load_data(load_data), .load_valid(lv[2]), .load_ready(rdy_o[2]),
    .en(en[2]), .x(x_o[2]), .x_valid(xv_o[2]), .busy(busy_o[2]), .done(done_o[2])
  );

  function automatic int hold_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  task automatic cmp(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk(input int i, input string tag, input logic ex, input logic exv,
                     input logic eb, input logic ed, input logic er);
    cmp($sformatf("%s[%0d].x", tag, i), x_o[i], ex);
    cmp($sformatf("%s[%0d].x_valid", tag, i), xv_o[i], exv);
    cmp($sformatf("%s[%0d].busy", tag, i), busy_o[i], eb);
    cmp($sformatf("%s[%0d].done", tag, i), done_o[i], ed);
    cmp($sformatf("%s[%0d].load_ready", tag, i), rdy_o[i], er);
  endtask

  // mode 0: en=1 always; 1: random en and random loads while busy;
  // 2: en=0 for 4 cycles on bit 3 plus 8'hFF offered throughout the word.
  task automatic run_word(input int i, input logic [7:0] w, input int mode);
    int n, h, guard, stall, hold;
    bit e, msb;
    logic ebit;
    hold  = hold_of(i);
    msb   = msb_of(i);
    n     = 0;
    h     = 0;
    guard = 0;
    stall = 0;
    chk(i, "idle_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    load_data = w;
    lv[i]     = 1'b1;
    en[i]     = 1'($urandom_range(0, 1));  // en must not gate acceptance
    @(negedge CLK);
    lv[i] = 1'b0;
    while (n < 8 && guard < 300) begin
      ebit = msb ? w[7-n] : w[n];
      chk(i, $sformatf("bit%0d", n), ebit, 1'b1, 1'b1, 1'b0, 1'b0);
      if (mode == 0) e = 1'b1;
      else if (mode == 1) e = ($urandom_range(0, 3) != 0);
      else if (n == 3 && stall < 4) begin
        e = 1'b0;
        stall++;
      end else e = 1'b1;
      en[i] = e;
      if (mode == 2 || $urandom_range(0, 3) == 0) begin
        lv[i]     = 1'b1;
        load_data = (mode == 2) ? 8'hFF : 8'($urandom);
      end else begin
        lv[i] = 1'b0;
      end
      @(negedge CLK);
      guard++;
      if (e) begin
        h++;
        if (h == hold) begin
          h = 0;
          n++;
        end
      end
    end
    cmp("payload_bound", guard < 300, 1'b1);
    if (mode == 2) cmp("stalled_payload_cycles", guard == 12, 1'b1);
    chk(i, "done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    en[i] = 1'($urandom_range(0, 1));
    lv[i] = (mode == 2);  // a load offered in DONE must not be taken
    @(negedge CLK);
    chk(i, "idle_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lv[i] = 1'b0;
    en[i] = 1'b1;
    @(negedge CLK);
    chk(i, "idle_settle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    RESET     = 1'b1;
    lv        = 3'b111;
    en        = 3'b111;
    load_data = 8'hA5;

    // Reset dominates load_valid.
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) chk(i, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lv    = 3'b000;
    RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) chk(i, "post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Directed: 8'hB4 through each configuration.
    run_word(0, 8'hB4, 0);
    run_word(1, 8'hB4, 0);
    run_word(2, 8'hB4, 0);
    // Stall on bit 3 with an ignored 8'hFF offered while busy.
    run_word(0, 8'hB4, 2);

    // Reset mid-word during bit 5.
    load_data = 8'h5A;
    lv[0]     = 1'b1;
    en[0]     = 1'b1;
    @(negedge CLK);
    lv[0] = 1'b0;
    repeat (5) @(negedge CLK);
    cmp("pre_abort_bit5", x_o[0], 1'b0);  // bit 5 of 8'h5A, MSB first
    cmp("pre_abort_busy", busy_o[0], 1'b1);
    RESET = 1'b1;
    #1;
    chk(0, "abort_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    chk(0, "abort_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    chk(0, "abort_no_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_word(0, 8'h81, 0);

    // Random words with random en and random loads while busy.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        w = 8'($urandom);
        run_word(i, w, (k == 0) ? 0 : 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
